// File: rtl/fifo_byte_packer.sv
// Drains bytes from an 8-bit FIFO and packs NBYTES of them little-endian into one word on a valid/ready port.
// Optional parity output enabled by defining FIFO_BYTE_PACKER_PARITY_EN.
module fifo_byte_packer #(
    parameter int NBYTES = 4,
    parameter int CNT_W  = $clog2(NBYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Q_EMPTY,
    input  logic [7:0]            data_out,
    output logic                  read_event,
    input  logic                  flush,
    output logic [8*NBYTES-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [CNT_W-1:0]      word_bytes
`ifdef FIFO_BYTE_PACKER_PARITY_EN
    ,
    output logic                  word_parity
`endif
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_CAPT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(NBYTES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [8*NBYTES-1:0]   shreg_q, shreg_d;
    logic                  valid_q, valid_d;
    logic                  pop_req;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shreg_d = shreg_q;
        valid_d = valid_q;
        pop_req = 1'b0;
        case (state_q)
            ST_REQ: begin
                // A pending flush beats an available byte, so no read is issued alongside it.
                if ((count_q == FULL) || (flush && (count_q != '0))) begin
                    state_d = ST_OUT;
                    valid_d = 1'b1;
                end else if (!Q_EMPTY) begin
                    pop_req = 1'b1;
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (count_q == CNT_W'(k)) begin
                        shreg_d[8*k +: 8] = data_out;
                    end
                end
                count_d = count_q + CNT_W'(1);
                // The byte that fills the word goes straight to OUT: word_valid in cycle 2*NBYTES.
                if (count_d == FULL) begin
                    state_d = ST_OUT;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_OUT: begin
                if (valid_q && word_ready) begin
                    shreg_d = '0;
                    count_d = '0;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            count_q <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            valid_q <= valid_d;
        end
    end

    // The pop is a Mealy output; it is masked while reset is held so no byte leaves the FIFO.
    assign read_event = pop_req & ~rst;
    assign word_out   = shreg_q;
    assign word_valid = valid_q;
    assign word_bytes = count_q;

`ifdef FIFO_BYTE_PACKER_PARITY_EN
    assign word_parity = ^shreg_q;
`endif

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer: FIFO model feeds bytes, a scoreboard holds expected words.
module tb_fifo_byte_packer;

    localparam int NBYTES = 4;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int W      = 8 * NBYTES;

    logic             clk;
    logic             rst;
    logic             Q_EMPTY;
    logic [7:0]       data_out;
    logic             read_event;
    logic             flush;
    logic [W-1:0]     word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CNT_W-1:0] word_bytes;
`ifdef FIFO_BYTE_PACKER_PARITY_EN
    logic             word_parity;
`endif

    fifo_byte_packer #(.NBYTES(NBYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .Q_EMPTY    (Q_EMPTY),
        .data_out   (data_out),
        .read_event (read_event),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_bytes (word_bytes)
`ifdef FIFO_BYTE_PACKER_PARITY_EN
        ,
        .word_parity(word_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] word;
        int           nb;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fq[$];
    int         re_log[$];
    int         vl_log[$];
    int         n_checks = 0;
    int         n_fails  = 0;
    int         cyc      = 0;
    bit         pend     = 1'b0;
    bit         rst_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input logic [W-1:0] w, input int n, input bit expect_word);
        exp_t e;
        for (int i = 0; i < n; i++) fq.push_back(w[8*i +: 8]);
        if (expect_word) begin
            e.word = w;
            e.nb   = n;
            sb.push_back(e);
        end
    endtask

    // One clock: inputs are final on entry, outputs are checked before the edge, FIFO responds after it.
    task automatic cycle();
        exp_t e;
        #1;
        cyc++;
        if (rst) check("rst_no_read", 64'(read_event), 64'(0));
        if (rst_prev) begin
            check("rst_valid", 64'(word_valid), 64'(0));
            check("rst_word", 64'(word_out), 64'(0));
            check("rst_bytes", 64'(word_bytes), 64'(0));
`ifdef FIFO_BYTE_PACKER_PARITY_EN
            check("rst_parity", 64'(word_parity), 64'(0));
`endif
        end
        if (read_event) begin
            re_log.push_back(cyc);
            pend = 1'b1;
        end
        if (word_valid) begin
            vl_log.push_back(cyc);
            check("no_read_in_out", 64'(read_event), 64'(0));
            check("word_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb[0];
                check("word_out", 64'(word_out), 64'(e.word));
                check("word_bytes", 64'(word_bytes), 64'(e.nb));
`ifdef FIFO_BYTE_PACKER_PARITY_EN
                check("word_parity", 64'(word_parity), 64'(^e.word));
`endif
                if (word_ready) void'(sb.pop_front());
            end
        end
        rst_prev = rst;
        @(posedge clk);
        #1;
        if (pend) begin
            check("fifo_underflow", 64'(fq.size() != 0), 64'(1));
            if (fq.size() != 0) data_out = fq.pop_front();
            pend = 1'b0;
        end
        Q_EMPTY = (fq.size() == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) cycle();
        check(tag, 64'(sb.size()), 64'(0));
        run(2);
    endtask

    initial begin
        rst        = 1'b1;
        Q_EMPTY    = 1'b1;
        data_out   = 8'h00;
        flush      = 1'b0;
        word_ready = 1'b0;
        run(3);
        rst = 1'b0;

        // Reset mid-word: two bytes captured, then reset, then a full fresh word.
        push_bytes(32'h0000_BBAA, 2, 1'b0);
        run(5);
        check("pre_reset_reads", 64'(re_log.size()), 64'(2));
        rst = 1'b1;
        push_bytes(32'h4433_2211, 4, 1'b1);
        run(3);
        rst        = 1'b0;
        word_ready = 1'b1;
        drain("drain_reset", 40);

        // Steady stream: reads every other cycle, word_valid 8 cycles after the first read.
        re_log.delete();
        vl_log.delete();
        push_bytes(32'h4433_2211, 4, 1'b1);
        run(12);
        check("steady_reads", 64'(re_log.size()), 64'(4));
        if (re_log.size() == 4) begin
            for (int i = 1; i < 4; i++) check("steady_read_gap", 64'(re_log[i] - re_log[0]), 64'(2 * i));
        end
        check("steady_valid_cycles", 64'(vl_log.size()), 64'(1));
        if (vl_log.size() == 1 && re_log.size() != 0) begin
            check("steady_latency", 64'(vl_log[0] - re_log[0]), 64'(2 * NBYTES));
        end
        drain("drain_steady", 10);

        // Back-pressure: first word held for 10 cycles, no reads, then second word follows.
        word_ready = 1'b0;
        push_bytes(32'h4433_2211, 4, 1'b1);
        push_bytes(32'h8877_6655, 4, 1'b1);
        for (int i = 0; i < 40 && !word_valid; i++) cycle();
        check("bp_valid_reached", 64'(word_valid), 64'(1));
        re_log.delete();
        vl_log.delete();
        run(10);
        check("bp_no_reads", 64'(re_log.size()), 64'(0));
        check("bp_valid_held", 64'(vl_log.size()), 64'(10));
        word_ready = 1'b1;
        drain("drain_bp", 60);

        // Flush: three bytes, then flush emits a zero-padded partial word; flush with count 0 is ignored.
        re_log.delete();
        push_bytes(32'h00C3_B2A1, 3, 1'b0);
        run(7);
        check("flush_reads", 64'(re_log.size()), 64'(3));
        begin
            exp_t e;
            e.word = 32'h00C3_B2A1;
            e.nb   = 3;
            sb.push_back(e);
        end
        flush = 1'b1;
        drain("drain_flush", 10);
        vl_log.delete();
        run(6);
        check("flush_empty_no_word", 64'(vl_log.size()), 64'(0));
        flush = 1'b0;

        // Empty stall mid-word: no reads and no word while the FIFO stays empty.
        push_bytes(32'h0000_6B5A, 2, 1'b0);
        run(6);
        re_log.delete();
        vl_log.delete();
        run(20);
        check("stall_no_reads", 64'(re_log.size()), 64'(0));
        check("stall_no_word", 64'(vl_log.size()), 64'(0));
        fq.push_back(8'h7C);
        fq.push_back(8'h8D);
        begin
            exp_t e;
            e.word = 32'h8D7C_6B5A;
            e.nb   = 4;
            sb.push_back(e);
        end
        drain("drain_stall", 20);

        // Parity patterns (odd and even weight).
        push_bytes(32'h0000_0001, 4, 1'b1);
        push_bytes(32'h0000_0003, 4, 1'b1);
        drain("drain_parity", 40);

        check("fifo_leftover", 64'(fq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
